// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit count needed to hold 0..w-1; at least one bit so the counter always exists.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_sub_8_full_sub.sv
// One-bit full subtractor cell: diff = x - y - bi, bo is the borrow out.
module full_sub (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  assign diff = x ^ y ^ bi;
  assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub_8.sv
// Bit-serial subtractor (d = a - b - bin, LSB first) behind a start/done handshake.
// Build option SERIAL_SUB_SAT_EN: clamp d to zero when the final borrow is set.
module serial_sub_8
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;

  logic             w_diff;
  logic             w_bo;
  logic [WIDTH-1:0] w_res_next;

  full_sub u_cell (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .bi   (r_br),
    .diff (w_diff),
    .bo   (w_bo)
  );

  // Result register fills from the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign w_res_next = {w_diff, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_d     <= '0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_res   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_br  <= w_bo;
          r_res <= w_res_next;
          if (r_cnt == LAST) begin
`ifdef SERIAL_SUB_SAT_EN
            r_d <= w_bo ? '0 : w_res_next;
`else
            r_d <= w_res_next;
`endif
            r_bout  <= w_bo;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign d    = r_d;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_sub_8.sv
// Scoreboard bench for serial_sub_8: a cycle model of the handshake predicts
// busy/done/d/bout every cycle, and each done pops one expected result.
module tb_serial_sub_8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] d;
  logic       bout;

  int n_checks = 0;
  int n_errors = 0;

  serial_sub_8 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [8:0] r;
    r = {1'b0, x} - {1'b0, y} - {8'd0, c};
`ifdef SERIAL_SUB_SAT_EN
    if (r[8]) r[7:0] = 8'h00;
`endif
    return r;
  endfunction

  // Reference handshake model and scoreboard
  logic [8:0] sb_q[$];
  int         m_state;
  int         m_cnt;
  logic [8:0] m_pend;
  logic [7:0] m_d;
  logic       m_bout;
  logic       m_busy;
  logic       m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_cnt = 0; m_pend = '0;
      m_d = '0; m_bout = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      sb_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_state == 1) begin
        if (m_cnt == 7) begin
          m_state = 2; m_busy = 1'b0; m_done = 1'b1;
          m_d = m_pend[7:0]; m_bout = m_pend[8];
        end else begin
          m_cnt++;
        end
      end else if (start) begin
        m_pend = ref_sub(a, b, bin);
        sb_q.push_back(m_pend);
        m_state = 1; m_cnt = 0; m_busy = 1'b1;
      end else begin
        m_state = 0; m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check_eq("busy", busy, m_busy);
      check_eq("done", done, m_done);
      check_eq("d_hold", d, m_d);
      check_eq("bout_hold", bout, m_bout);
      if (done) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 1, 0);
        end else begin
          logic [8:0] e;
          e = sb_q.pop_front();
          check_eq("sb_d", d, e[7:0]);
          check_eq("sb_bout", bout, e[8]);
        end
      end
    end
  end

  // Issue one op at the current negedge and return at the negedge where done is seen.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin, output int lat);
    start = 1'b1; a = ia; b = ib; bin = ibin;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    lat = 1;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check_eq("done_timeout", 0, 1);
    $display("op 0x%02h - 0x%02h - %0d -> d=0x%02h bout=%0d lat=%0d", ia, ib, ibin, d, bout, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         lat;
    int         done_at[$];
    int         ndone;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_d", d, 0);
    check_eq("rst_bout", bout, 0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);

    do_op(8'h50, 8'h20, 1'b0, lat);
    check_eq("lat_50_20", lat, 9);
    check_eq("d_50_20", d, 8'h30);
    check_eq("bout_50_20", bout, 0);
    repeat (2) @(negedge clk);

    do_op(8'h00, 8'h01, 1'b0, lat);
`ifdef SERIAL_SUB_SAT_EN
    check_eq("d_00_01", d, 8'h00);
`else
    check_eq("d_00_01", d, 8'hFF);
`endif
    check_eq("bout_00_01", bout, 1);

    do_op(8'hFF, 8'hFF, 1'b1, lat);
`ifdef SERIAL_SUB_SAT_EN
    check_eq("d_FF_FF_1", d, 8'h00);
`else
    check_eq("d_FF_FF_1", d, 8'hFF);
`endif
    check_eq("bout_FF_FF_1", bout, 1);

    do_op(8'h80, 8'h7F, 1'b1, lat);
    check_eq("d_80_7F_1", d, 8'h00);
    check_eq("bout_80_7F_1", bout, 0);
    repeat (3) @(negedge clk);

    // start held high for 20 cycles with operands changing every cycle
    for (int i = 0; i < 20; i++) begin
      start = 1'b1;
      if (i == 0) begin
        a = 8'h10; b = 8'h03; bin = 1'b0;
      end else begin
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      end
      @(negedge clk);
      if (done) begin
        if (done_at.size() == 0) check_eq("b2b_first_d", d, 8'h0D);
        done_at.push_back(i + 1);
      end
    end
    start = 1'b0;
    check_eq("b2b_done_count", done_at.size(), 2);
    if (done_at.size() == 2) check_eq("b2b_spacing", done_at[1] - done_at[0], 9);
    repeat (12) @(negedge clk);

    // async reset in the 4th RUN cycle
    start = 1'b1; a = 8'h40; b = 8'h01; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_d", d, 0);
    check_eq("arst_bout", bout, 0);
    @(posedge clk); #2 rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_eq("arst_no_done", ndone, 0);
    do_op(8'h05, 8'h05, 1'b0, lat);
    check_eq("d_05_05", d, 8'h00);
    check_eq("bout_05_05", bout, 0);

    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      do_op(ra, rb, rc, lat);
    end
    repeat (4) @(negedge clk);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
